// File: rtl/axi_mm_pattern_pkg.sv
// Types, AXI constants and the beat pattern shared by the burst pattern generator and checker.
// Beat k of a pass carries byte i = seed + i, where the seed starts at 8'h80 and advances once per beat.
package axi_mm_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEND_AR    = 2'd1,
        READ_BURST = 2'd2,
        FINISH     = 2'd3
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [7:0] PATTERN_SEED0  = 8'h80;
    localparam int         PAT_MAX_W      = 1024;

    // Returns a PAT_MAX_W-wide vector; callers truncate it to their data width.
    function automatic logic [PAT_MAX_W-1:0] pattern_beat(input logic [7:0] seed, input int width);
        logic [PAT_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < PAT_MAX_W/8; i++) begin
            if (i < width/8) v[i*8 +: 8] = seed + 8'(i);
        end
        return v;
    endfunction

endpackage

// File: rtl/axi_pattern_cmp.sv
// Registered compare of one accepted R beat against the expected pattern.
// The beat address travels with the result so the error logic sees both in the same cycle.
module axi_pattern_cmp
    import axi_mm_pattern_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_beat_vld,
    input  logic [DW-1:0] i_rdata,
    input  logic [7:0]    i_seed,
    input  logic [AW-1:0] i_addr,
    output logic          o_vld,
    output logic          o_mismatch,
    output logic [AW-1:0] o_addr
);

    logic [DW-1:0] w_pat;
    logic          r_vld;
    logic          r_mismatch;
    logic [AW-1:0] r_addr;

    assign w_pat = DW'(pattern_beat(i_seed, DW));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld      <= 1'b0;
            r_mismatch <= 1'b0;
            r_addr     <= '0;
        end else begin
            r_vld      <= i_beat_vld;
            r_mismatch <= i_beat_vld && (i_rdata != w_pat);
            if (i_beat_vld) r_addr <= i_addr;
        end
    end

    assign o_vld      = r_vld;
    assign o_mismatch = r_mismatch;
    assign o_addr     = r_addr;

endmodule

// File: rtl/data_chk_axi_mm_burst.sv
// AXI4 MM read-back checker: reads BYTES from BASE_ADDR in fixed INCR bursts and compares
// every beat with the generator pattern, reporting mismatch count, first failing address and protocol errors.
module data_chk_axi_mm_burst
    import axi_mm_pattern_pkg::*;
#(
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int MAX_BURST_LEN   = 16,
    parameter int C_AXI_SIZE      = $clog2(AXI_DATA_WIDTH/8),
    parameter int C_AXI_ARLEN     = MAX_BURST_LEN-1,
    parameter int BURST_CNT_WIDTH = $clog2(MAX_BURST_LEN)+1
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR,
    input  logic [15:0]               BYTES,
    input  logic                      START,
    output logic                      BUSY,
    output logic                      DONE,
    output logic [15:0]               ERR_CNT,
    output logic [AXI_ADDR_WIDTH-1:0] FIRST_ERR_ADDR,
    output logic                      RRESP_ERR,
    output logic                      LAST_ERR,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam int AW          = AXI_ADDR_WIDTH;
    localparam int BPB         = AXI_DATA_WIDTH/8;
    localparam int BURST_BYTES = MAX_BURST_LEN*BPB;
    localparam int BCW         = BURST_CNT_WIDTH;

    state_t               r_state;
    logic [AW-1:0]        r_burst_addr;
    logic [15:0]          r_bytes;
    logic [16:0]          r_bytes_read;
    logic [BCW-1:0]       r_beat;
    logic [7:0]           r_seed;
    logic                 r_arvalid;
    logic                 r_rready;
    logic                 r_busy;
    logic                 r_done;
    logic [15:0]          r_err_cnt;
    logic [AW-1:0]        r_first_err_addr;
    logic                 r_have_err;
    logic                 r_rresp_err;
    logic                 r_last_err;

    logic                 w_beat_acc;
    logic                 w_last_beat;
    logic [AW-1:0]        w_beat_addr;
    logic [16:0]          w_bytes_next;
    logic                 w_cmp_vld;
    logic                 w_cmp_mismatch;
    logic [AW-1:0]        w_cmp_addr;

    assign w_beat_acc   = (r_state == READ_BURST) && m_axi_rvalid && r_rready;
    assign w_last_beat  = (r_beat == BCW'(C_AXI_ARLEN));
    assign w_beat_addr  = r_burst_addr + AW'(r_beat) * AW'(BPB);
    assign w_bytes_next = r_bytes_read + 17'(BPB);

    axi_pattern_cmp #(
        .DW (AXI_DATA_WIDTH),
        .AW (AW)
    ) u_cmp (
        .i_clk      (ACLK),
        .i_rst      (ARESET),
        .i_beat_vld (w_beat_acc),
        .i_rdata    (m_axi_rdata),
        .i_seed     (r_seed),
        .i_addr     (w_beat_addr),
        .o_vld      (w_cmp_vld),
        .o_mismatch (w_cmp_mismatch),
        .o_addr     (w_cmp_addr)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state          <= IDLE;
            r_burst_addr     <= '0;
            r_bytes          <= '0;
            r_bytes_read     <= '0;
            r_beat           <= '0;
            r_seed           <= '0;
            r_arvalid        <= 1'b0;
            r_rready         <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_have_err       <= 1'b0;
            r_rresp_err      <= 1'b0;
            r_last_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Compare results land one cycle after the beat, so the final beat is counted before DONE.
            if (w_cmp_vld && w_cmp_mismatch) begin
                if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
                if (!r_have_err) begin
                    r_have_err       <= 1'b1;
                    r_first_err_addr <= w_cmp_addr;
                end
            end

            case (r_state)
                IDLE: begin
                    if (START) begin
                        r_burst_addr     <= BASE_ADDR;
                        r_bytes          <= BYTES;
                        r_bytes_read     <= '0;
                        r_beat           <= '0;
                        r_seed           <= PATTERN_SEED0;
                        r_err_cnt        <= '0;
                        r_first_err_addr <= '0;
                        r_have_err       <= 1'b0;
                        r_rresp_err      <= 1'b0;
                        r_last_err       <= 1'b0;
                        r_busy           <= 1'b1;
                        if (BYTES == 16'd0) begin
                            r_state <= FINISH;
                        end else begin
                            r_state   <= SEND_AR;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                SEND_AR: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_beat    <= '0;
                        r_state   <= READ_BURST;
                    end
                end
                READ_BURST: begin
                    if (w_beat_acc) begin
                        if (m_axi_rresp != AXI_RESP_OKAY) r_rresp_err <= 1'b1;
                        if (m_axi_rlast != w_last_beat)   r_last_err  <= 1'b1;
                        r_beat       <= r_beat + BCW'(1);
                        r_bytes_read <= w_bytes_next;
                        r_seed       <= r_seed + 8'd1;
                        // A misplaced RLAST is only flagged; the beat count alone closes the burst.
                        if (w_last_beat) begin
                            r_rready     <= 1'b0;
                            r_beat       <= '0;
                            r_burst_addr <= r_burst_addr + AW'(BURST_BYTES);
                            if (w_bytes_next >= {1'b0, r_bytes}) begin
                                r_state <= FINISH;
                            end else begin
                                r_state   <= SEND_AR;
                                r_arvalid <= 1'b1;
                            end
                        end
                    end
                end
                FINISH: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign BUSY           = r_busy;
    assign DONE           = r_done;
    assign ERR_CNT        = r_err_cnt;
    assign FIRST_ERR_ADDR = r_first_err_addr;
    assign RRESP_ERR      = r_rresp_err;
    assign LAST_ERR       = r_last_err;

    assign m_axi_araddr   = r_burst_addr;
    assign m_axi_arprot   = 3'b000;
    assign m_axi_arvalid  = r_arvalid;
    assign m_axi_arlen    = 8'(C_AXI_ARLEN);
    assign m_axi_arsize   = 3'(C_AXI_SIZE);
    assign m_axi_arburst  = AXI_BURST_INCR;
    assign m_axi_rready   = r_rready;

endmodule

// File: tb/tb_data_chk_axi_mm_burst.sv
// Bench for data_chk_axi_mm_burst: a memory-slave model driven at the falling edge, with expected
// AR addresses and final status queued at pass start and popped as the DUT issues ARs and DONE.
module tb_data_chk_axi_mm_burst;

    typedef struct {
        logic [15:0] err;
        logic [31:0] addr;
        logic        rresp;
        logic        last;
    } res_t;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] BASE_ADDR;
    logic [15:0] BYTES;
    logic        START;
    logic        BUSY, DONE, RRESP_ERR, LAST_ERR;
    logic [15:0] ERR_CNT;
    logic [31:0] FIRST_ERR_ADDR;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot, m_axi_arsize;
    logic        m_axi_arvalid, m_axi_arready;
    logic [7:0]  m_axi_arlen;
    logic [1:0]  m_axi_arburst;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

    data_chk_axi_mm_burst dut (
        .ACLK(ACLK), .ARESET(ARESET), .BASE_ADDR(BASE_ADDR), .BYTES(BYTES), .START(START),
        .BUSY(BUSY), .DONE(DONE), .ERR_CNT(ERR_CNT), .FIRST_ERR_ADDR(FIRST_ERR_ADDR),
        .RRESP_ERR(RRESP_ERR), .LAST_ERR(LAST_ERR),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 ACLK = ~ACLK;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_ar[$];
    res_t        exp_res[$];

    // slave model state
    bit          sl_stall = 1'b0;
    int          sl_corrupt_k = -1, sl_resp_k = -1, sl_last14_burst = -1;
    int          sl_k = 0, sl_beat = 0, sl_bursts = 0;
    int          ar_wait = 0, r_wait = 0, ar_cnt = 0;
    bit          prev_ar_hold = 1'b0;
    logic [31:0] prev_araddr = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] tb_pat(input int k);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[i*8 +: 8] = 8'((128 + k + i) % 256);
        return v;
    endfunction

    // memory slave: R side evaluated before AR so data never precedes its AR handshake
    initial begin
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        forever begin
            @(negedge ACLK);
            if (sl_bursts > 0 && r_wait == 0) begin
                m_axi_rvalid = 1'b1;
                m_axi_rdata  = tb_pat(sl_k) ^ ((sl_k == sl_corrupt_k) ? 32'h0000_0100 : 32'h0);
                m_axi_rresp  = (sl_k == sl_resp_k) ? 2'b10 : 2'b00;
                m_axi_rlast  = (sl_k/16 == sl_last14_burst) ? (sl_beat == 14) : (sl_beat == 15);
            end else begin
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
                if (r_wait > 0) r_wait--;
            end
            if (m_axi_rvalid && m_axi_rready) begin
                sl_k++;
                sl_beat++;
                if (sl_beat == 16) begin
                    sl_beat = 0;
                    sl_bursts--;
                end
                r_wait = sl_stall ? int'($urandom_range(0, 7)) : 0;
            end

            if (m_axi_arvalid && prev_ar_hold)
                chk("araddr_stable", 64'(m_axi_araddr), 64'(prev_araddr));
            if (m_axi_arvalid && ar_wait > 0) begin
                m_axi_arready = 1'b0;
                ar_wait--;
            end else begin
                m_axi_arready = 1'b1;
            end
            if (m_axi_arvalid && m_axi_arready) begin
                ar_cnt++;
                chk("ar_expected", 64'(exp_ar.size() > 0), 64'd1);
                if (exp_ar.size() > 0) chk("ar_addr", 64'(m_axi_araddr), 64'(exp_ar.pop_front()));
                sl_bursts++;
                prev_ar_hold = 1'b0;
                ar_wait = sl_stall ? int'($urandom_range(0, 7)) : 0;
            end else begin
                prev_ar_hold = m_axi_arvalid;
            end
            prev_araddr = m_axi_araddr;
        end
    end

    task automatic sl_setup(input logic [31:0] base, input int bytes, input bit stall,
                            input int ck, input int rk, input int lb, output int nb);
        nb = (bytes + 63) / 64;
        for (int i = 0; i < nb; i++) exp_ar.push_back(base + 32'(i*64));
        sl_stall = stall; sl_corrupt_k = ck; sl_resp_k = rk; sl_last14_burst = lb;
        sl_k = 0; sl_beat = 0; sl_bursts = 0; r_wait = 0; ar_cnt = 0;
        ar_wait = stall ? int'($urandom_range(0, 7)) : 0;
    endtask

    task automatic run_pass(input logic [31:0] base, input int bytes, input bit stall,
                            input int ck, input int rk, input int lb, input bit poke);
        int   nb, cyc;
        res_t e, r;
        sl_setup(base, bytes, stall, ck, rk, lb, nb);
        e.err   = (ck >= 0 && ck < nb*16) ? 16'd1 : 16'd0;
        e.addr  = (ck >= 0 && ck < nb*16) ? base + 32'(ck*4) : 32'h0;
        e.rresp = (rk >= 0 && rk < nb*16);
        e.last  = (lb >= 0 && lb < nb);
        exp_res.push_back(e);

        @(negedge ACLK); #1;
        BASE_ADDR = base; BYTES = 16'(bytes); START = 1'b1;
        @(negedge ACLK); #1;
        START = 1'b0; cyc = 1;
        chk("busy_after_start", 64'(BUSY), 64'd1);
        chk("done_low_early", 64'(DONE), 64'd0);
        if (poke) begin
            START = 1'b1; BASE_ADDR = base ^ 32'h0000_1000; BYTES = 16'(bytes) + 16'd64;
        end
        while (!DONE && cyc < 40000) begin
            @(negedge ACLK); #1;
            cyc++;
            START = 1'b0;
        end
        chk("done_seen", 64'(DONE), 64'd1);
        chk("busy_at_done", 64'(BUSY), 64'd0);
        if (bytes == 0) chk("done_latency", 64'(cyc), 64'd2);
        r = exp_res.pop_front();
        chk("err_cnt", 64'(ERR_CNT), 64'(r.err));
        chk("first_err_addr", 64'(FIRST_ERR_ADDR), 64'(r.addr));
        chk("rresp_err", 64'(RRESP_ERR), 64'(r.rresp));
        chk("last_err", 64'(LAST_ERR), 64'(r.last));
        chk("ar_count", 64'(ar_cnt), 64'(nb));
        chk("ar_pending", 64'(exp_ar.size()), 64'd0);
        @(negedge ACLK); #1;
        chk("done_pulse", 64'(DONE), 64'd0);
        chk("status_hold", 64'(ERR_CNT), 64'(r.err));
    endtask

    initial begin
        int nb, cyc;
        ARESET = 1'b1; START = 1'b0; BASE_ADDR = '0; BYTES = '0;
        repeat (3) @(negedge ACLK);
        #1;
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_done", 64'(DONE), 64'd0);
        chk("rst_err_cnt", 64'(ERR_CNT), 64'd0);
        chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("rst_rready", 64'(m_axi_rready), 64'd0);
        chk("arlen", 64'(m_axi_arlen), 64'd15);
        chk("arsize", 64'(m_axi_arsize), 64'd2);
        chk("arburst", 64'(m_axi_arburst), 64'd1);
        chk("arprot", 64'(m_axi_arprot), 64'd0);
        ARESET = 1'b0;

        run_pass(32'h1000_0000, 128, 1'b0, -1, -1, -1, 1'b1);  // clean, START poked while busy
        run_pass(32'h1000_0000, 128, 1'b0, 21, -1, -1, 1'b0);  // burst 2 beat 5 corrupted
        run_pass(32'h1000_0000, 128, 1'b1, -1, -1, -1, 1'b0);  // random stalls
        run_pass(32'h1000_0000, 128, 1'b1, 7, -1, -1, 1'b0);   // stalls with an error
        run_pass(32'h0000_2000, 128, 1'b0, -1, 3, 0, 1'b0);    // SLVERR beat, early RLAST
        run_pass(32'h0000_3000, 0, 1'b0, -1, -1, -1, 1'b1);    // zero bytes
        run_pass(32'hFFFF_FFC0, 100, 1'b1, 30, -1, -1, 1'b0);  // partial burst, address wrap

        // reset in the middle of the second burst
        sl_setup(32'h4000_0000, 128, 1'b0, 2, 5, -1, nb);
        @(negedge ACLK); #1;
        BASE_ADDR = 32'h4000_0000; BYTES = 16'd128; START = 1'b1;
        @(negedge ACLK); #1;
        START = 1'b0; cyc = 0;
        while (sl_k < 20 && cyc < 1000) begin
            @(negedge ACLK); #1;
            cyc++;
        end
        chk("pre_rst_err_cnt", 64'(ERR_CNT), 64'd1);
        chk("pre_rst_busy", 64'(BUSY), 64'd1);
        ARESET = 1'b1;
        @(negedge ACLK); #1;
        chk("mid_rst_busy", 64'(BUSY), 64'd0);
        chk("mid_rst_err_cnt", 64'(ERR_CNT), 64'd0);
        chk("mid_rst_first_addr", 64'(FIRST_ERR_ADDR), 64'd0);
        chk("mid_rst_rresp_err", 64'(RRESP_ERR), 64'd0);
        chk("mid_rst_rready", 64'(m_axi_rready), 64'd0);
        chk("mid_rst_araddr", 64'(m_axi_araddr), 64'd0);
        exp_ar.delete();
        sl_bursts = 0; sl_k = 0; sl_beat = 0; m_axi_rvalid = 1'b0;
        ARESET = 1'b0;
        run_pass(32'h4000_0000, 128, 1'b0, -1, -1, -1, 1'b0);

        run_pass(32'h0000_0000, 65535, 1'b0, 16383, -1, -1, 1'b0); // max BYTES, last beat bad

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
